// File: rtl/step_ramp_pkg.sv
// Shared definitions for the trapezoidal step-rate ramp generator.
package step_ramp_pkg;

  // Ramp controller states (2-bit encoding shared with any debug/readback logic)
  typedef enum logic [1:0] {
    RAMP_IDLE   = 2'd0,
    RAMP_ACCEL  = 2'd1,
    RAMP_CRUISE = 2'd2,
    RAMP_DECEL  = 2'd3
  } ramp_state_e;

  // Idle period value: all ones, i.e. the slowest possible rate
  localparam logic RAMP_SPEED_RESET_BIT = 1'b1;

endpackage

// File: rtl/step_ramp_tick_gen.sv
// Update-interval tick generator: fires once every div_i clocks (0 treated as 1).
module tick_gen #(
  parameter int DIV_SIZE = 32
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic [DIV_SIZE-1:0] div_i,
  output logic                tick_o
);

  logic [DIV_SIZE-1:0] cnt_q, cnt_d;
  logic [DIV_SIZE-1:0] last;

  // Terminal count is div-1; a divider of 0 degenerates to a tick every cycle
  assign last   = (div_i == '0) ? '0 : div_i - DIV_SIZE'(1);
  assign tick_o = (cnt_q == last);

  // Clear wins over wrap; otherwise count up and wrap on the tick
  always_comb begin
    cnt_d = cnt_q + DIV_SIZE'(1);
    if (clear_i || tick_o) cnt_d = '0;
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/step_ramp.sv
// Trapezoidal velocity-profile generator producing the step-rate period for one axis.
module step_ramp
  import step_ramp_pkg::*;
#(
  parameter int SPEED_SIZE = 64,
  parameter int DIV_SIZE   = 32
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic [SPEED_SIZE-1:0] start_period_in,
  input  logic [SPEED_SIZE-1:0] target_period_in,
  input  logic [SPEED_SIZE-1:0] ramp_step_in,
  input  logic [DIV_SIZE-1:0]   update_div_in,
  output logic [SPEED_SIZE-1:0] speed_out,
  output logic                  step_enable_out,
  output logic                  busy_out,
  output logic                  at_speed_out
);

  ramp_state_e           state_q;
  logic [SPEED_SIZE-1:0] speed_q, s_q, t_q, r_q;
  logic [DIV_SIZE-1:0]   d_q;
  logic                  en_q, busy_q, at_q;

  logic                  tick;
  logic [SPEED_SIZE:0]   sum;
  logic [SPEED_SIZE-1:0] add_sat, sub_sat, accel_nxt, decel_nxt;
  logic                  stop_go, accel_done, cnt_clr;

  // Saturating period arithmetic; R = 0 means jump straight to the end point
  assign sum       = {1'b0, speed_q} + {1'b0, r_q};
  assign add_sat   = sum[SPEED_SIZE] ? '1 : sum[SPEED_SIZE-1:0];
  assign sub_sat   = (speed_q >= r_q) ? (speed_q - r_q) : '0;
  assign accel_nxt = ((r_q == '0) || (sub_sat <= t_q)) ? t_q : sub_sat;
  assign decel_nxt = ((r_q == '0) || (add_sat >= s_q)) ? s_q : add_sat;

  // Counter restarts on every state entry; IDLE holds it cleared
  assign stop_go    = stop_in && ((state_q == RAMP_ACCEL) || (state_q == RAMP_CRUISE));
  assign accel_done = (state_q == RAMP_ACCEL) && tick && (accel_nxt == t_q);
  assign cnt_clr    = (state_q == RAMP_IDLE) || stop_go || accel_done;

  tick_gen #(.DIV_SIZE(DIV_SIZE)) u_tick (
    .clk_i     (clk_in),
    .reset_n_i (reset_n_in),
    .clear_i   (cnt_clr),
    .div_i     (d_q),
    .tick_o    (tick)
  );

  // Ramp FSM with registered period and status flags
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q <= RAMP_IDLE;
      speed_q <= {SPEED_SIZE{RAMP_SPEED_RESET_BIT}};
      s_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      at_q    <= 1'b0;
    end else begin
      case (state_q)
        RAMP_IDLE: begin
          // A simultaneous stop cancels the start
          if (start_in && !stop_in) begin
            s_q    <= start_period_in;
            t_q    <= target_period_in;
            r_q    <= ramp_step_in;
            d_q    <= update_div_in;
            en_q   <= 1'b1;
            busy_q <= 1'b1;
            if (target_period_in < start_period_in) begin
              state_q <= RAMP_ACCEL;
              speed_q <= start_period_in;
            end else begin
              state_q <= RAMP_CRUISE;
              speed_q <= target_period_in;
              at_q    <= 1'b1;
            end
          end
        end
        RAMP_ACCEL: begin
          if (stop_in) begin
            state_q <= RAMP_DECEL;
          end else if (tick) begin
            speed_q <= accel_nxt;
            if (accel_nxt == t_q) begin
              state_q <= RAMP_CRUISE;
              at_q    <= 1'b1;
            end
          end
        end
        RAMP_CRUISE: begin
          if (stop_in) begin
            state_q <= RAMP_DECEL;
            at_q    <= 1'b0;
          end
        end
        RAMP_DECEL: begin
          // Cruise at or above S (T >= S case) leaves right away
          if (speed_q >= s_q) begin
            state_q <= RAMP_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tick) begin
            speed_q <= decel_nxt;
            if (decel_nxt >= s_q) begin
              state_q <= RAMP_IDLE;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= RAMP_IDLE;
      endcase
    end
  end

  assign speed_out       = speed_q;
  assign step_enable_out = en_q;
  assign busy_out        = busy_q;
  assign at_speed_out    = at_q;

endmodule

// File: doc/step_ramp.md
# step_ramp

Trapezoidal velocity-profile generator that drives the step-rate inputs of `motor_driver`. It produces `speed_out`, the clock-divider period that feeds `speed_in` (larger means slower), and `step_enable_out`, which feeds `step_enable_in`. On command it ramps the period linearly from a start period down to a target period, holds it, then ramps back up and disables stepping. It sits between the motion-command logic and `motor_driver`, one instance per axis.

## Interface
Parameters:
- `SPEED_SIZE`, 64: width of all period values; matches `motor_driver.speed_in`.
- `DIV_SIZE`, 32: width of the update-interval counter.

Ports:
- `clk_in` input 1: system clock. One clock domain.
- `reset_n_in` input 1: reset, synchronous, active-low.
- `start_in` input 1: single-cycle pulse; begin a move.
- `stop_in` input 1: single-cycle pulse; begin deceleration.
- `start_period_in` input SPEED_SIZE: slowest period, used at ramp start and end.
- `target_period_in` input SPEED_SIZE: cruise period.
- `ramp_step_in` input SPEED_SIZE: period change applied per update.
- `update_div_in` input DIV_SIZE: clocks between updates.
- `speed_out` output SPEED_SIZE: current period, to `motor_driver.speed_in`.
- `step_enable_out` output 1: to `motor_driver.step_enable_in`.
- `busy_out` output 1: high in any state other than IDLE.
- `at_speed_out` output 1: high in CRUISE.

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL.
- Inputs are latched into internal registers S, T, R and D on `start_in` in IDLE. Input changes while busy have no effect.
- **IDLE**
  - `start_in` with T < S: go to ACCEL, set `speed_out` = S.
  - `start_in` with T ≥ S: go directly to CRUISE, set `speed_out` = T.
  - `stop_in` is ignored. If `start_in` and `stop_in` arrive in the same cycle, stop wins and the block stays in IDLE.
- **ACCEL**
  - On each update: `speed_out` = max(`speed_out` − R, T), with a saturating subtract (no underflow).
  - R = 0 jumps straight to T.
  - When the new value equals T, go to CRUISE in the same cycle.
- **CRUISE**: hold `speed_out`.
- **Stop handling**: `stop_in` in ACCEL or CRUISE goes to DECEL, and the update counter clears.
- **DECEL**
  - On each update: `speed_out` = min(`speed_out` + R, S), with a saturating add (no overflow).
  - R = 0 jumps to S.
  - When the value is ≥ S, go to IDLE.
  - If `speed_out` is already ≥ S on entry (the T ≥ S case), go to IDLE on the next cycle.
- `start_in` while busy is ignored. `stop_in` in DECEL is ignored.
- **Update tick**
  - The counter clears on every state entry.
  - A tick fires when counter = D − 1; the counter then wraps to 0.
  - D = 0 is treated as 1, i.e. a tick every cycle.
- `step_enable_out` = 1 in ACCEL, CRUISE and DECEL; 0 in IDLE.

## Timing
- Reset values:
  - state IDLE
  - `speed_out` = all ones
  - `step_enable_out` = 0
  - `busy_out` = 0
  - `at_speed_out` = 0
  - counter 0
- Reset asserted mid-move returns to these values on the next edge, with no deceleration.
- `start_in` sampled at edge N: state, `speed_out` = S, `step_enable_out` and `busy_out` are valid after edge N.
- The first ACCEL update is visible after edge N + D.
- `stop_in` sampled at edge M: state is DECEL after M; the first increment is visible after M + D.
- Return to IDLE: `speed_out` stays at S, and `step_enable_out` and `busy_out` fall on the same edge.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared header `macros.v` gets:
  - state encodings `RAMP_IDLE`, `RAMP_ACCEL`, `RAMP_CRUISE`, `RAMP_DECEL` (2-bit)
  - `RAMP_SPEED_RESET` (all ones)
- Sub-module `tick_gen`: DIV_SIZE counter with synchronous clear, a D = 0 → 1 rule, and a one-cycle `tick_out`.
- Saturating add/sub stays inline in `step_ramp`.

## Test plan
- Reset: hold `reset_n_in` = 0 for 3 cycles → `speed_out` = 64'hFFFF_FFFF_FFFF_FFFF, all flags 0.
- Full trapezoid with S = 1000, T = 400, R = 100, D = 4:
  - `start_in` → period 1000, then 900…400 at 4-cycle spacing; `at_speed_out` rises with 400.
  - `stop_in` → 500…1000 at 4-cycle spacing, then IDLE with `step_enable_out` = 0.
- Saturation, S = 1000, T = 950, R = 100, D = 1: one update → 950 (not 900), CRUISE.
- Early stop: stop after 2 ACCEL updates (period 800) → DECEL 900, 1000, IDLE. Counter restarts, so the first increment comes exactly D cycles after stop.
- Edge inputs:
  - T = 1200 ≥ S = 1000 → CRUISE at 1200; stop → IDLE next cycle.
  - R = 0 → immediate jump.
  - D = 0 → behaves as D = 1.
  - start + stop in the same cycle in IDLE → stays IDLE.
- Reset mid-ACCEL → all outputs at reset values after one edge; a subsequent start works normally.
